// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl: sequencer for a 32x32 multiplier. It issues eight partial
// products (one byte of A times one 16-bit half of B) to an external
// accumulator, then pulses done for one cycle.
//
// Handshake: start is sampled only in IDLE. An accepted start latches a_in and
// b_in into a and b on that edge. start seen in any other state is dropped and
// not queued. busy is high for the eight MUL cycles. done is high for exactly
// one cycle after them, and the accumulated product is valid in that cycle.
// There is no back-pressure, so the result must be taken when done is high.
module mult32x32_ctrl (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [2:0]  shift_sel,
    output logic        upd_prod,
    output logic        clr_prod,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg,
    output logic [2:0]  step_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        in_mul;

    // State, step counter and operand registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state logic: IDLE -> MUL0..MUL7 -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MUL;
                    step_d  = 3'd0;
                    a_d     = a_in;
                    b_d     = b_in;
                end
            end
            S_MUL: begin
                if (step_q == 3'd7) begin
                    state_d = S_DONE;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    // Output decode. The step's low two bits pick the A byte and its top bit
    // picks the B half. The shift in bytes is then a_sel + 2*b_sel.
    always_comb begin
        in_mul    = (state_q == S_MUL);
        a_sel     = 2'd0;
        b_sel     = 1'b0;
        shift_sel = 3'd0;
        if (in_mul) begin
            a_sel     = step_q[1:0];
            b_sel     = step_q[2];
            shift_sel = {1'b0, step_q[1:0]} + {1'b0, step_q[2], 1'b0};
        end
        upd_prod  = in_mul;
        busy      = in_mul;
        done      = (state_q == S_DONE);
        // Clearing during reset lets the accumulator start from zero.
        clr_prod  = !reset || ((state_q == S_IDLE) && start);
        state_dbg = state_q;
        step_dbg  = step_q;
    end

    assign a = a_q;
    assign b = b_q;

endmodule
